// File: rtl/bbc_csr_pkg.sv
// rtl/bbc_csr_pkg.sv - shared CSR bus request/response types and master state encoding
package bbc_csr_pkg;

  localparam int CSR_MASTER_TIMEOUT_DEFAULT = 15;

  typedef struct packed {
    logic        valid;
    logic        read_not_write;
    logic [15:0] select;
    logic [15:0] address;
    logic [31:0] data;
  } t_csr_request;

  typedef struct packed {
    logic        ack;
    logic        read_data_valid;
    logic [31:0] read_data;
  } t_csr_response;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    READ_WAIT = 2'd2,
    COMPLETE  = 2'd3
  } t_csr_master_state;

endpackage

// File: rtl/bbc_csr_master_arbiter_if.sv
// rtl/bbc_csr_master_arbiter_if.sv - requester handshakes and shared CSR bus of the master arbiter
interface bbc_csr_master_arbiter_if;

  logic        req0_valid;
  logic        req0_read_not_write;
  logic [15:0] req0_select;
  logic [15:0] req0_address;
  logic [31:0] req0_data;
  logic        req0_done;
  logic        req0_error;
  logic [31:0] req0_read_data;

  logic        req1_valid;
  logic        req1_read_not_write;
  logic [15:0] req1_select;
  logic [15:0] req1_address;
  logic [31:0] req1_data;
  logic        req1_done;
  logic        req1_error;
  logic [31:0] req1_read_data;

  logic        csr_request__valid;
  logic        csr_request__read_not_write;
  logic [15:0] csr_request__select;
  logic [15:0] csr_request__address;
  logic [31:0] csr_request__data;

  logic        csr_response__ack;
  logic        csr_response__read_data_valid;
  logic [31:0] csr_response__read_data;

  // Arbiter side: owns the shared bus and the completion outputs.
  modport master (
    input  req0_valid, req0_read_not_write, req0_select, req0_address, req0_data,
    output req0_done, req0_error, req0_read_data,
    input  req1_valid, req1_read_not_write, req1_select, req1_address, req1_data,
    output req1_done, req1_error, req1_read_data,
    output csr_request__valid, csr_request__read_not_write, csr_request__select,
    output csr_request__address, csr_request__data,
    input  csr_response__ack, csr_response__read_data_valid, csr_response__read_data
  );

  // Environment side: requesters and the OR-combined CSR targets.
  modport slave (
    output req0_valid, req0_read_not_write, req0_select, req0_address, req0_data,
    input  req0_done, req0_error, req0_read_data,
    output req1_valid, req1_read_not_write, req1_select, req1_address, req1_data,
    input  req1_done, req1_error, req1_read_data,
    input  csr_request__valid, csr_request__read_not_write, csr_request__select,
    input  csr_request__address, csr_request__data,
    output csr_response__ack, csr_response__read_data_valid, csr_response__read_data
  );

endinterface

// File: rtl/bbc_csr_rr_arbiter2.sv
// rtl/bbc_csr_rr_arbiter2.sv - two-way round-robin grant with registered last winner
module bbc_csr_rr_arbiter2 (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic req0,
  input  logic req1,
  output logic grant_valid,
  output logic grant_idx
);

  logic last_grant_q, last_grant_d;

  // Grant whichever requests; on contention, the one that did not win last time.
  always_comb begin
    grant_valid  = enable && (req0 || req1);
    grant_idx    = (req0 && req1) ? ~last_grant_q : req1;
    last_grant_d = grant_valid ? grant_idx : last_grant_q;
  end

  // last_grant resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/bbc_csr_master_arbiter.sv
// rtl/bbc_csr_master_arbiter.sv - two-requester CSR bus master with round-robin grant and timeout
module bbc_csr_master_arbiter
  import bbc_csr_pkg::*;
#(
  parameter int TIMEOUT = CSR_MASTER_TIMEOUT_DEFAULT
) (
  input logic                       clk,
  input logic                       reset_n,
  bbc_csr_master_arbiter_if.master  bus
);

  localparam logic [1:0] S_IDLE      = 2'(IDLE);
  localparam logic [1:0] S_ISSUE     = 2'(ISSUE);
  localparam logic [1:0] S_READ_WAIT = 2'(READ_WAIT);
  localparam logic [1:0] S_COMPLETE  = 2'(COMPLETE);
  localparam logic [7:0] TIMER_LAST  = 8'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic [7:0]    timer_q, timer_d;
  t_csr_request  req_q, req_d;
  logic          gnt_q, gnt_d;
  logic          done0_q, done0_d, done1_q, done1_d;
  logic          err0_q, err0_d, err1_q, err1_d;
  logic [31:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  t_csr_response rsp;
  t_csr_request  sel_req;
  logic          arb_valid, arb_idx;
  logic          complete, cpl_err;
  logic [31:0]   cpl_data;

  bbc_csr_rr_arbiter2 u_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (state_q == S_IDLE),
    .req0        (bus.req0_valid),
    .req1        (bus.req1_valid),
    .grant_valid (arb_valid),
    .grant_idx   (arb_idx)
  );

  assign rsp = '{ack:             bus.csr_response__ack,
                 read_data_valid: bus.csr_response__read_data_valid,
                 read_data:       bus.csr_response__read_data};

  // Fields of the currently granted requester, ready to be latched onto the bus.
  always_comb begin
    sel_req                = '0;
    sel_req.read_not_write = arb_idx ? bus.req1_read_not_write : bus.req0_read_not_write;
    sel_req.select         = arb_idx ? bus.req1_select         : bus.req0_select;
    sel_req.address        = arb_idx ? bus.req1_address        : bus.req0_address;
    sel_req.data           = arb_idx ? bus.req1_data           : bus.req0_data;
  end

  // Sequence one transaction: grant, wait for ack / read data or time out, then complete.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    req_d    = req_q;
    gnt_d    = gnt_q;
    complete = 1'b0;
    cpl_err  = 1'b0;
    cpl_data = '0;
    case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          state_d = S_ISSUE;
          timer_d = '0;
          gnt_d   = arb_idx;
          req_d   = sel_req;
        end
      end
      S_ISSUE: begin
        // An ack only counts once valid is actually on the bus.
        if (req_q.valid && rsp.ack) begin
          if (!req_q.read_not_write) begin
            complete = 1'b1;
          end else if (rsp.read_data_valid) begin
            complete = 1'b1;
            cpl_data = rsp.read_data;
          end else begin
            state_d = S_READ_WAIT;
            timer_d = '0;
          end
        end else if (timer_q == TIMER_LAST) begin
          complete = 1'b1;
          cpl_err  = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_READ_WAIT: begin
        if (rsp.read_data_valid) begin
          complete = 1'b1;
          cpl_data = rsp.read_data;
        end else if (timer_q == TIMER_LAST) begin
          complete = 1'b1;
          cpl_err  = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_COMPLETE: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (complete) begin
      state_d = S_COMPLETE;
    end
    // Valid rises one cycle into ISSUE and drops as soon as the transaction completes,
    // so every transaction starts with a fresh rising edge after a low gap.
    req_d.valid = ((state_q == S_ISSUE) || (state_q == S_READ_WAIT)) &&
                  ((state_d == S_ISSUE) || (state_d == S_READ_WAIT));
  end

  // Completion pulse and result routed only to the granted requester; results hold otherwise.
  always_comb begin
    done0_d  = complete && !gnt_q;
    done1_d  = complete && gnt_q;
    err0_d   = err0_q;
    err1_d   = err1_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (done0_d) begin
      err0_d   = cpl_err;
      rdata0_d = cpl_data;
    end
    if (done1_d) begin
      err1_d   = cpl_err;
      rdata1_d = cpl_data;
    end
  end

  // State and registered outputs; reset aborts any transaction without a done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      req_q    <= '0;
      gnt_q    <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      req_q    <= req_d;
      gnt_q    <= gnt_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign bus.csr_request__valid          = req_q.valid;
  assign bus.csr_request__read_not_write = req_q.read_not_write;
  assign bus.csr_request__select         = req_q.select;
  assign bus.csr_request__address        = req_q.address;
  assign bus.csr_request__data           = req_q.data;
  assign bus.req0_done                   = done0_q;
  assign bus.req0_error                  = err0_q;
  assign bus.req0_read_data              = rdata0_q;
  assign bus.req1_done                   = done1_q;
  assign bus.req1_error                  = err1_q;
  assign bus.req1_read_data              = rdata1_q;

endmodule

// File: tb/tb_bbc_csr_master_arbiter.sv
// tb/tb_bbc_csr_master_arbiter.sv - randomized self-checking bench for the CSR master arbiter
module tb_bbc_csr_master_arbiter;

  localparam int          TIMEOUT = 15;
  localparam logic [15:0] TGT_SEL = 16'h0003;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bbc_csr_master_arbiter_if bus ();

  bbc_csr_master_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;
  int dcnt0 = 0, dcnt1 = 0, xcnt0 = 0, xcnt1 = 0;
  int order_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Target at select TGT_SEL: read data is a fixed function of the address.
  function automatic logic [31:0] tgt_data(input logic [15:0] addr);
    if (addr == 16'h0020) return 32'h12345678;
    return {addr ^ 16'hA5C3, ~addr};
  endfunction

  // Expected outcome: a missing target or a read whose data never comes back times out.
  function automatic void predict(input logic rnw, input logic [15:0] sel, input logic [15:0] addr,
                                  output logic err, output logic [31:0] rd);
    logic served;
    logic data_back;
    served    = (sel == TGT_SEL);
    data_back = !rnw || addr[14] || !addr[15];
    err       = !(served && data_back);
    rd        = (err || !rnw) ? 32'd0 : tgt_data(addr);
  endfunction

  // Target responder: acks one cycle after seeing a valid rising edge; read data one cycle
  // after ack (addr[14]: with the ack, addr[15] without addr[14]: never).
  logic        prev_v, ack_pend, rdv_pend, cur_read, rise, same;
  logic [15:0] cur_addr;
  logic [15:0] last_sel, last_addr;
  logic [31:0] last_data;
  logic        last_rnw;
  int          rises = 0;
  int          low_cnt = 100;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_v = 1'b0; ack_pend = 1'b0; rdv_pend = 1'b0; cur_read = 1'b0; cur_addr = '0;
      low_cnt = 100;
      bus.csr_response__ack = 1'b0;
      bus.csr_response__read_data_valid = 1'b0;
      bus.csr_response__read_data = '0;
    end else begin
      rise   = bus.csr_request__valid && !prev_v;
      prev_v = bus.csr_request__valid;
      if (rise) begin
        rises++;
        check("bus_low_gap", (low_cnt >= 2) ? 32'd1 : 32'd0, 32'd1);
        last_sel  = bus.csr_request__select;
        last_addr = bus.csr_request__address;
        last_data = bus.csr_request__data;
        last_rnw  = bus.csr_request__read_not_write;
      end
      low_cnt = bus.csr_request__valid ? 0 : low_cnt + 1;
      same = ack_pend && cur_read && cur_addr[14];
      bus.csr_response__ack = ack_pend;
      bus.csr_response__read_data_valid = rdv_pend || same;
      bus.csr_response__read_data = (rdv_pend || same) ? tgt_data(cur_addr) : 32'd0;
      rdv_pend = ack_pend && cur_read && !cur_addr[14] && !cur_addr[15];
      ack_pend = rise && (bus.csr_request__select == TGT_SEL);
      if (ack_pend) begin
        cur_read = bus.csr_request__read_not_write;
        cur_addr = bus.csr_request__address;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.req0_done) dcnt0++;
    if (bus.req1_done) dcnt1++;
    if (bus.req0_done || bus.req1_done)
      check("done_exclusive", 32'(bus.req0_done & bus.req1_done), 32'd0);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input int n, input logic v, input logic rnw, input logic [15:0] sel,
                       input logic [15:0] addr, input logic [31:0] data);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_read_not_write = rnw; bus.req0_select = sel;
      bus.req0_address = addr; bus.req0_data = data;
    end else begin
      bus.req1_valid = v; bus.req1_read_not_write = rnw; bus.req1_select = sel;
      bus.req1_address = addr; bus.req1_data = data;
    end
  endtask

  // One requester transaction, entered at a negedge; lat counts rising edges until done is seen.
  task automatic xact(input int n, input logic rnw, input logic [15:0] sel, input logic [15:0] addr,
                      input logic [31:0] data, output int lat, output logic err, output logic [31:0] rd);
    bit    seen;
    string tg;
    seen = 1'b0;
    tg   = (n == 0) ? "req0" : "req1";
    drive(n, 1'b1, rnw, sel, addr, data);
    lat = 0;
    while (!seen && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      seen = (n == 0) ? bus.req0_done : bus.req1_done;
    end
    check({tg, "_done_seen"}, 32'(seen), 32'd1);
    err = (n == 0) ? bus.req0_error : bus.req1_error;
    rd  = (n == 0) ? bus.req0_read_data : bus.req1_read_data;
    drive(n, 1'b0, rnw, sel, addr, data);
    if (seen) begin
      order_q.push_back(n);
      if (n == 0) xcnt0++; else xcnt1++;
    end else begin
      lat = 0;
    end
  endtask

  task automatic run(input int n, input logic rnw, input logic [15:0] sel, input logic [15:0] addr,
                     input logic [31:0] data, input int exp_lat);
    int          lat;
    logic        err, e_err;
    logic [31:0] rd, e_rd;
    string       tg;
    tg = (n == 0) ? "req0" : "req1";
    predict(rnw, sel, addr, e_err, e_rd);
    xact(n, rnw, sel, addr, data, lat, err, rd);
    if (lat > 0) begin
      check({tg, "_error"}, 32'(err), 32'(e_err));
      if (rnw || e_err) check({tg, "_read_data"}, rd, e_rd);
      if (exp_lat > 0) check({tg, "_latency"}, lat, exp_lat);
    end
  endtask

  task automatic rand_run(input int n, input bit easy);
    logic        rnw;
    logic [15:0] sel, addr;
    logic [31:0] data;
    rnw  = 1'($urandom_range(0, 1));
    sel  = (easy || $urandom_range(0, 3) != 0) ? TGT_SEL : 16'h00FF;
    addr = 16'($urandom);
    if (easy) addr[15:14] = 2'b00;
    else if ($urandom_range(0, 3) != 0) addr[15] = 1'b0;
    data = $urandom;
    run(n, rnw, sel, addr, data, -1);
  endtask

  int r0, d0, d1;

  initial begin
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req0_done", 32'(bus.req0_done), 32'd0);
    check("rst_req0_error", 32'(bus.req0_error), 32'd0);
    check("rst_req0_read_data", bus.req0_read_data, 32'd0);
    check("rst_req1_done", 32'(bus.req1_done), 32'd0);
    check("rst_req1_error", 32'(bus.req1_error), 32'd0);
    check("rst_req1_read_data", bus.req1_read_data, 32'd0);
    check("rst_bus_valid", 32'(bus.csr_request__valid), 32'd0);
    check("rst_bus_rnw", 32'(bus.csr_request__read_not_write), 32'd0);
    check("rst_bus_select", 32'(bus.csr_request__select), 32'd0);
    check("rst_bus_address", 32'(bus.csr_request__address), 32'd0);
    check("rst_bus_data", bus.csr_request__data, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Both requesters contend from reset and keep re-requesting: grants alternate from req0.
    order_q.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) begin rand_run(0, 1'b1); @(negedge clk); end
      end
      begin
        for (int j = 0; j < 4; j++) begin rand_run(1, 1'b1); @(negedge clk); end
      end
    join
    check("sat_grant_count", order_q.size(), 32'd8);
    for (int k = 0; k < order_q.size(); k++) check("sat_grant_order", order_q[k], 32'(k % 2));
    repeat (3) @(negedge clk);

    r0 = rises;
    run(0, 1'b0, 16'h0003, 16'h0010, 32'hDEADBEEF, 4);
    check("write_bus_rises", rises - r0, 32'd1);
    check("write_bus_select", 32'(last_sel), 32'h0003);
    check("write_bus_address", 32'(last_addr), 32'h0010);
    check("write_bus_data", last_data, 32'hDEADBEEF);
    check("write_bus_rnw", 32'(last_rnw), 32'd0);
    check("req1_done_count", dcnt1, xcnt1);
    repeat (3) @(negedge clk);

    run(1, 1'b1, 16'h0003, 16'h0020, 32'h0, 5);
    check("read_gap_c0", 32'(bus.csr_request__valid), 32'd0);
    @(negedge clk);
    check("read_gap_c1", 32'(bus.csr_request__valid), 32'd0);
    repeat (3) @(negedge clk);

    run(0, 1'b0, 16'h00FF, 16'h0030, 32'h00000001, TIMEOUT + 1);
    repeat (3) @(negedge clk);
    run(1, 1'b0, 16'h0003, 16'h0034, 32'h00005A5A, 4);
    repeat (3) @(negedge clk);
    run(0, 1'b1, 16'h0003, 16'h8040, 32'h0, TIMEOUT + 4);
    repeat (3) @(negedge clk);
    run(1, 1'b1, 16'h0003, 16'h4044, 32'h0, 4);
    repeat (3) @(negedge clk);

    fork
      begin
        for (int i = 0; i < 12; i++) begin
          rand_run(0, 1'b0);
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
      begin
        for (int j = 0; j < 12; j++) begin
          rand_run(1, 1'b0);
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
    join
    repeat (4) @(negedge clk);
    check("req0_done_count", dcnt0, xcnt0);
    check("req1_done_count", dcnt1, xcnt1);

    // Reset while req0's read waits for data, then both contend: req0 must win.
    d0 = dcnt0;
    d1 = dcnt1;
    drive(0, 1'b1, 1'b1, 16'h0003, 16'h8080, 32'h0);
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_mid_bus_valid", 32'(bus.csr_request__valid), 32'd0);
    drive(0, 1'b0, 1'b1, 16'h0003, 16'h8080, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mid_no_done0", dcnt0 - d0, 32'd0);
    check("rst_mid_no_done1", dcnt1 - d1, 32'd0);
    order_q.delete();
    fork
      run(0, 1'b0, 16'h0003, 16'h0100, 32'hCAFEF00D, 4);
      run(1, 1'b0, 16'h0003, 16'h0104, 32'h0BADF00D, -1);
    join
    check("post_rst_grant_count", order_q.size(), 32'd2);
    if (order_q.size() == 2) begin
      check("post_rst_first_grant", order_q[0], 32'd0);
      check("post_rst_second_grant", order_q[1], 32'd1);
    end
    repeat (3) @(negedge clk);
    check("final_req0_done_count", dcnt0, xcnt0);
    check("final_req1_done_count", dcnt1, xcnt1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
